// File: rtl/video_timing_gen.sv
// Raster counters with sync/data-enable delayed to line up with the layer colour
// that returns PIPE_DELAY cycles after the counts; also frame-level status.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 7,
  parameter int unsigned BPP        = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic signed [31:0]  ext_count_h,
  output logic signed [31:0]  ext_count_v,
  input  logic [BPP-1:0]      ext_color,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic [BPP-1:0]      vga_color,
  output logic                vblank_start,
  output logic [31:0]         frame_count
);

  localparam logic [31:0] H_TOTAL  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] V_TOTAL  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] H_ACT_W  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_W  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [31:0] h_q, h_d;
  logic [31:0] v_q, v_d;
  logic [31:0] frame_q, frame_d;
  logic        run_q;
  logic        vblank_q;

  logic hs_raw, vs_raw, de_raw;
  logic [PIPE_DELAY-1:0] hs_dly_q, vs_dly_q, de_dly_q;

  logic           hs_q, vs_q, de_q;
  logic [BPP-1:0] color_q;

  // run_q holds the counts at (0,0) for one extra cycle after reset release
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (run_q) begin
      if (h_q == H_TOTAL - 32'd1) begin
        h_d = '0;
        if (v_q == V_TOTAL - 32'd1) begin
          v_d     = '0;
          frame_d = frame_q + 32'd1;
        end else begin
          v_d = v_q + 32'd1;
        end
      end else begin
        h_d = h_q + 32'd1;
      end
    end
  end

  assign de_raw = (h_q < H_ACT_W) && (v_q < V_ACT_W);
  assign hs_raw = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_raw = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q      <= '0;
      v_q      <= '0;
      frame_q  <= '0;
      run_q    <= 1'b0;
      vblank_q <= 1'b0;
      hs_dly_q <= {PIPE_DELAY{~SYNC_POL}};
      vs_dly_q <= {PIPE_DELAY{~SYNC_POL}};
      de_dly_q <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      de_q     <= 1'b0;
      color_q  <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      frame_q  <= frame_d;
      run_q    <= 1'b1;
      vblank_q <= (h_d == 32'd0) && (v_d == V_ACT_W);
      hs_dly_q[0] <= hs_raw;
      vs_dly_q[0] <= vs_raw;
      de_dly_q[0] <= de_raw;
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
        de_dly_q[i] <= de_dly_q[i-1];
      end
      hs_q    <= hs_dly_q[PIPE_DELAY-1];
      vs_q    <= vs_dly_q[PIPE_DELAY-1];
      de_q    <= de_dly_q[PIPE_DELAY-1];
      color_q <= de_dly_q[PIPE_DELAY-1] ? ext_color : '0;
    end
  end

  assign ext_count_h  = $signed(h_q);
  assign ext_count_v  = $signed(v_q);
  assign vga_hs       = hs_q;
  assign vga_vs       = vs_q;
  assign vga_de       = de_q;
  assign vga_color    = color_q;
  assign vblank_start = vblank_q;
  assign frame_count  = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a default-timing instance and a small, high-active-sync,
// short-pipe instance run side by side from a shared clock and reset.
module tb_video_timing_gen;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic [7:0]  col;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [31:0] a_h, a_v, b_h, b_v;
  logic [7:0]  a_ext, b_ext, a_col, b_col;
  logic        a_hs, a_vs, a_de, a_vb, b_hs, b_vs, b_de, b_vb;
  logic [31:0] a_fc, b_fc;

  video_timing_gen u_a (
    .clk(clk), .reset(rst_n), .ext_count_h(a_h), .ext_count_v(a_v),
    .ext_color(a_ext), .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de),
    .vga_color(a_col), .vblank_start(a_vb), .frame_count(a_fc)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .PIPE_DELAY(3), .BPP(8)
  ) u_b (
    .clk(clk), .reset(rst_n), .ext_count_h(b_h), .ext_count_v(b_v),
    .ext_color(b_ext), .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de),
    .vga_color(b_col), .vblank_start(b_vb), .frame_count(b_fc)
  );

  int HA[2] = '{640, 16};
  int VA[2] = '{480, 10};
  int HT[2] = '{800, 31};
  int VT[2] = '{525, 17};
  int HSS[2] = '{656, 20};
  int HSE[2] = '{752, 26};
  int VSS[2] = '{490, 12};
  int VSE[2] = '{492, 14};
  int PD[2] = '{7, 3};
  logic POL[2] = '{1'b0, 1'b1};

  int          mh[2], mv[2];
  logic        mrun[2];
  logic [31:0] mf[2];
  int          vb_seen[2];
  int          vb_exp[2];

  exp_t expq_a[$], expq_b[$];
  logic [7:0] colq_a[$], colq_b[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic refill(input int k);
    exp_t e;
    e.h = 16'hFFFF; e.v = 16'hFFFF;
    e.hs = ~POL[k]; e.vs = ~POL[k]; e.de = 1'b0; e.col = 8'h00;
    if (k == 0) begin
      expq_a.delete();
      for (int i = 0; i <= PD[0]; i++) expq_a.push_back(e);
    end else begin
      expq_b.delete();
      for (int i = 0; i <= PD[1]; i++) expq_b.push_back(e);
    end
  endtask

  task automatic model_edge(input int k, input logic r);
    if (!r) begin
      mh[k] = 0; mv[k] = 0; mf[k] = 0; mrun[k] = 1'b0;
      refill(k);
    end else if (!mrun[k]) begin
      mrun[k] = 1'b1;
    end else if (mh[k] == HT[k] - 1) begin
      mh[k] = 0;
      if (mv[k] == VT[k] - 1) begin
        mv[k] = 0;
        mf[k] = mf[k] + 32'd1;
      end else begin
        mv[k] = mv[k] + 1;
      end
    end else begin
      mh[k] = mh[k] + 1;
    end
  endtask

  task automatic sample(input int k);
    logic [31:0] oh, ov, ofc;
    logic        ohs, ovs, ode, ovb;
    logic [7:0]  ocol, drv;
    exp_t        e, f;
    string       p;
    logic        evb;
    if (k == 0) begin
      p = "a_"; oh = a_h; ov = a_v; ofc = a_fc; ohs = a_hs; ovs = a_vs; ode = a_de; ovb = a_vb; ocol = a_col;
    end else begin
      p = "b_"; oh = b_h; ov = b_v; ofc = b_fc; ohs = b_hs; ovs = b_vs; ode = b_de; ovb = b_vb; ocol = b_col;
    end
    check({p, "count_h"}, oh, 32'(mh[k]));
    check({p, "count_v"}, ov, 32'(mv[k]));
    check({p, "frame_count"}, ofc, mf[k]);
    evb = (mh[k] == 0) && (mv[k] == VA[k]);
    check({p, "vblank_start"}, {31'd0, ovb}, {31'd0, evb});
    if (evb) vb_exp[k]++;
    if (ovb) vb_seen[k]++;

    e.h  = 16'(mh[k]);
    e.v  = 16'(mv[k]);
    e.de = (mh[k] < HA[k]) && (mv[k] < VA[k]);
    e.hs = (mh[k] >= HSS[k] && mh[k] < HSE[k]) ? POL[k] : ~POL[k];
    e.vs = (mv[k] >= VSS[k] && mv[k] < VSE[k]) ? POL[k] : ~POL[k];
    e.col = e.de ? 8'(mh[k]) : 8'h00;
    if (k == 0) begin
      expq_a.push_back(e); f = expq_a.pop_front();
      colq_a.push_back(8'(mh[k])); drv = colq_a.pop_front(); a_ext = drv;
    end else begin
      expq_b.push_back(e); f = expq_b.pop_front();
      colq_b.push_back(8'(mh[k])); drv = colq_b.pop_front(); b_ext = drv;
    end
    check({p, "vga_hs"}, {31'd0, ohs}, {31'd0, f.hs});
    check({p, "vga_vs"}, {31'd0, ovs}, {31'd0, f.vs});
    check({p, "vga_de"}, {31'd0, ode}, {31'd0, f.de});
    check({p, "vga_color"}, {24'd0, ocol}, {24'd0, f.col});
    // pixel alignment corners on the default-timing instance
    if (k == 0 && f.v == 16'd0) begin
      if (f.h == 16'd0)   check("a_pix_0_0", {24'd0, ocol}, 32'h00);
      if (f.h == 16'd639) check("a_pix_639_0", {24'd0, ocol}, 32'h7F);
      if (f.h == 16'd640) check("a_pix_640_0_forced", {24'd0, ocol}, 32'h00);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge(0, rst_n);
      model_edge(1, rst_n);
      @(negedge clk);
      sample(0);
      sample(1);
    end
  endtask

  initial begin
    a_ext = 8'h00;
    b_ext = 8'h00;
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; mf[k] = 0; mrun[k] = 1'b0;
      vb_seen[k] = 0; vb_exp[k] = 0;
    end
    for (int i = 0; i < PD[0]; i++) colq_a.push_back(8'h00);
    for (int i = 0; i < PD[1]; i++) colq_b.push_back(8'h00);

    rst_n = 1'b0;
    run_cycles(5);
    rst_n = 1'b1;
    run_cycles(1400);
    rst_n = 1'b0;
    run_cycles(1);
    rst_n = 1'b1;
    run_cycles(1100);

    check("b_vblank_pulses", 32'(vb_seen[1]), 32'(vb_exp[1]));
    check("b_frames_final", b_fc, mf[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates raster counters and display sync for one video output. It drives `ext_count_h`/`ext_count_v` into the sprite and bitmap layers, and takes back their pixel colour, which arrives `PIPE_DELAY` cycles later. It delays hsync, vsync and data-enable by the same amount, so the registered VGA/DVI outputs line up with the pixel data. It also provides frame-level status (vblank pulse, frame counter) for the CPU.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, active level of hsync/vsync (0 = active-low)
- `PIPE_DELAY`, 7, cycles from counter output to matching `ext_color`; legal range ≥ 1
- `BPP`, 8, colour width

Ports:
- `clk`  in  1  pixel clock; one pixel per cycle
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on rising `clk`)
- `ext_count_h`  out  32 signed  horizontal counter, zero-extended
- `ext_count_v`  out  32 signed  vertical counter, zero-extended
- `ext_color`  in  BPP  layer colour, valid `PIPE_DELAY` cycles after the counts it belongs to
- `vga_hs`  out  1  aligned hsync
- `vga_vs`  out  1  aligned vsync
- `vga_de`  out  1  aligned data-enable
- `vga_color`  out  BPP  aligned colour, forced to 0 outside the active area
- `vblank_start`  out  1  one-cycle pulse, not delayed
- `frame_count`  out  32  count of frames completed since reset

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`, `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (800 and 525 at defaults).
- `ext_count_h` counts 0..H_TOTAL-1.
  - At H_TOTAL-1 it wraps to 0.
  - On that same cycle `ext_count_v` advances; v wraps from V_TOTAL-1 to 0.
- Raw signals are computed combinationally from the current counts:
  - de = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs active when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC
  - Active level is `SYNC_POL`; inactive level is `!SYNC_POL`.
- The raw hs/vs/de triple passes through a `PIPE_DELAY`-deep shift register.
- Output register, written every cycle:
  - `vga_color <= de_dly ? ext_color : 0`
  - `vga_hs`, `vga_vs`, `vga_de` take `hs_dly`, `vs_dly`, `de_dly`.
- `vblank_start` is 1 for exactly the cycle in which the counts are (h=0, v=V_ACTIVE).
- `frame_count` increments by 1, wrapping at 2^32, on the cycle the counts move from (H_TOTAL-1, V_TOTAL-1) to (0, 0).
- Counters are plain binary; no further state machine exists. Parameters are static.
- Behaviour for a zero-width region parameter is undefined; the bench does not test it.

## Timing
- Reset values, present while `reset`=0 and on the first cycle after release:
  - `ext_count_h` = 0, `ext_count_v` = 0
  - `frame_count` = 0, `vblank_start` = 0
  - every delay-line stage cleared to inactive: hs/vs at `!SYNC_POL`, de = 0
  - `vga_hs` = `vga_vs` = `!SYNC_POL`, `vga_de` = 0, `vga_color` = 0
- Counts (0,0) are held through the first cycle after release. They advance on the following edge.
- Latency: counts presented in cycle t produce `vga_*` in cycle t+PIPE_DELAY+1.
  - Counts are registered and presented at t.
  - `ext_color` for those counts arrives at t+PIPE_DELAY.
  - The output register loads it at t+PIPE_DELAY+1.
- After reset release, `vga_de` and the syncs stay inactive for PIPE_DELAY+1 cycles, because the delay line has been flushed.
- Reset asserted mid-frame:
  - Counters return to (0,0) on the next edge.
  - The delay line clears the same edge; no partial sync pulse continues.
  - `frame_count` returns to 0.
- Simultaneous h wrap and v wrap: `frame_count` increments and `vblank_start` stays 0 on that cycle.

## Test plan
- Reset: hold `reset`=0 for 5 cycles, then release -> all outputs at reset values. `ext_count_h` reads 0,0,1,2… starting at the first released cycle. `vga_de`=0 for 8 cycles (defaults).
- Line timing: run one line at defaults -> raw hs low for h=656..751 (96 cycles). `vga_hs` low exactly 8 cycles later. h wraps 799→0 with v 0→1.
- Pixel alignment: drive `ext_color` = a model of an 8-bit function of the counts delayed by 7 (e.g. `h[7:0]`) -> `vga_color` equals `h[7:0]` of pixel (h,v) while `vga_de`=1, and is 0 during blanking. Check (0,0)=0x00, (639,0)=0x7F, (640,0)=0 forced.
- Frame timing: run 2 frames -> vs active for v=490..491 only. `vblank_start` pulses once per frame, at (0,480). `frame_count` reads 1 after (799,524)→(0,0), then 2.
- Mid-frame reset: assert `reset`=0 for 1 cycle at (300,200) -> next cycle counts (0,0), `vga_*` inactive, `frame_count`=0. Normal timing resumes.
- Parameter variant: `PIPE_DELAY`=3, `SYNC_POL`=1 -> outputs lag counts by 4 cycles and sync pulses are high-active.
